// File: rtl/pipe_front_regs_pkg.sv
// Shared constants for the front-end pipeline registers: control-bundle bit
// positions, the NOP encoding and the default fetch reset address.
package pipe_front_regs_pkg;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pipe_front_regs_flopenrc.sv
// Enabled register with synchronous clear; reset wins, clear only acts when
// the register is enabled, otherwise the input is loaded.
module flopenrc #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            if (clr) begin
                q <= CLR_VAL;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage core, driven by the hazard
// unit's stall/flush outputs, plus event counters and a sticky error flag.
module pipe_front_regs
    import pipe_front_regs_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int               CTRL_W   = 10,
    parameter int               CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              flushE,
    input  logic              pcsrcD,
    input  logic              jumpD,
    input  logic [WIDTH-1:0]  pcbranchD,
    input  logic [WIDTH-1:0]  pcjumpD,
    input  logic [31:0]       instrF,
    output logic [WIDTH-1:0]  pcF,
    output logic [31:0]       instrD,
    output logic [WIDTH-1:0]  pcplus4D,
    output logic              validD,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic [WIDTH-1:0]  rd1D,
    input  logic [WIDTH-1:0]  rd2D,
    input  logic [WIDTH-1:0]  signimmD,
    input  logic [4:0]        rsD,
    input  logic [4:0]        rtD,
    input  logic [4:0]        rdD,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [WIDTH-1:0]  rd1E,
    output logic [WIDTH-1:0]  rd2E,
    output logic [WIDTH-1:0]  signimmE,
    output logic [4:0]        rsE,
    output logic [4:0]        rtE,
    output logic [4:0]        rdE,
    output logic              validE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              hz_err
);

    localparam int IFID_W = 32 + WIDTH + 1;
    localparam int IDEX_W = CTRL_W + 3 * WIDTH + 15 + 1;
    localparam logic [IFID_W-1:0] IFID_CLR = {NOP_INSTR, {WIDTH{1'b0}}, 1'b0};

    logic             redirectD;
    logic             hzViolation;
    logic [WIDTH-1:0] pcplus4F;
    logic [WIDTH-1:0] pcNext;
    logic [CNT_W-1:0] stallCntReg;
    logic [CNT_W-1:0] flushCntReg;
    logic             hzErrReg;

    assign redirectD = jumpD | pcsrcD;
    assign pcplus4F  = pcF + WIDTH'(4);

    // Jump has priority over a taken branch.
    always_comb begin
        pcNext = pcplus4F;
        if (jumpD) begin
            pcNext = pcjumpD;
        end else if (pcsrcD) begin
            pcNext = pcbranchD;
        end
    end

    flopenrc #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) pcReg (
        .clk(clk), .reset(reset), .en(~stallF), .clr(1'b0),
        .d(pcNext), .q(pcF)
    );

    // A stalled IF/ID ignores the redirect: the enable gates the clear.
    flopenrc #(.WIDTH(IFID_W), .CLR_VAL(IFID_CLR)) ifidReg (
        .clk(clk), .reset(reset), .en(~stallD), .clr(redirectD),
        .d({instrF, pcplus4F, 1'b1}),
        .q({instrD, pcplus4D, validD})
    );

    flopenrc #(.WIDTH(IDEX_W)) idexReg (
        .clk(clk), .reset(reset), .en(1'b1), .clr(flushE),
        .d({ctrlD, rd1D, rd2D, signimmD, rsD, rtD, rdD, validD}),
        .q({ctrlE, rd1E, rd2E, signimmE, rsE, rtE, rdE, validE})
    );

    // Legal hazard control is stallF == stallD == flushE (all set or all clear).
    assign hzViolation = (stallD & ~flushE) | (stallF ^ stallD) | (flushE & ~stallD);

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCntReg <= '0;
            flushCntReg <= '0;
            hzErrReg    <= 1'b0;
        end else begin
            if (stallD && (stallCntReg != '1)) begin
                stallCntReg <= stallCntReg + CNT_W'(1);
            end
            if (redirectD && !stallD && (flushCntReg != '1)) begin
                flushCntReg <= flushCntReg + CNT_W'(1);
            end
            if (hzViolation) begin
                hzErrReg <= 1'b1;
            end
        end
    end

    assign stall_cnt = stallCntReg;
    assign flush_cnt = flushCntReg;
    assign hz_err    = hzErrReg;

endmodule
